i2s_transmitter: RTL

- Consumes 24-bit signed stereo samples from the wave generators/mixer through a valid/ready handshake.
- Serialises them to the audio codec DAC as a bus master: it generates BCLK and LRCLK from clk and drives SDATA.
- Sits between the voice mixer output and the codec pins; it is the sink end of the sample interface the generators drive.

---
 rtl/audio_pkg.sv | 34 +++
 rtl/i2s_transmitter_if.sv | 26 ++
 rtl/i2s_bclk_gen.sv | 43 ++++
 rtl/i2s_transmitter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types and codec clocking constants for the sample path
// (wave generators -> mixer -> I2S transmitter).
package audio_pkg;

  // Default sample width carried between generators, mixer and transmitter.
  localparam int unsigned SAMPLE_W_DEF = 24;

  // Default codec slot geometry: BCLK periods per channel slot.
  localparam int unsigned SLOT_W_DEF = 32;

  // System clock and default BCLK divider: 50 MHz / 16 / 64 = 48.83 kHz frames.
  localparam int unsigned SYS_CLK_HZ   = 50_000_000;
  localparam int unsigned BCLK_DIV_DEF = 16;

  typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  // Which channel slot the serial frame is currently in; encodes lrclk directly.
  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  // Resulting stereo frame rate for a given divider and slot width.
  function automatic int unsigned frame_rate_hz(input int unsigned bclk_div,
                                                input int unsigned slot_w);
    return SYS_CLK_HZ / (bclk_div * 2 * slot_w);
  endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Stereo sample handshake between the mixer (master) and the I2S
// transmitter (slave). A pair transfers on a cycle with valid && ready.
interface i2s_transmitter_if import audio_pkg::*; #(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
);

  logic signed [SAMPLE_W-1:0] left_in;
  logic signed [SAMPLE_W-1:0] right_in;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (
    output left_in,
    output right_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_in,
    input  right_in,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divides clk by BCLK_DIV into a 50% duty BCLK and
// flags the clk cycle on which BCLK is about to fall or rise.
module i2s_bclk_gen import audio_pkg::*; #(
  parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic bclk_o,
  output logic fall_tick_o,
  output logic rise_tick_o
);

  localparam int unsigned HALF = BCLK_DIV / 2;
  localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] TERM = CW'(HALF - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          terminal;

  // Half-period counter; BCLK toggles each time it wraps.
  always_comb begin
    terminal  = (div_cnt_q == TERM);
    div_cnt_d = terminal ? '0 : div_cnt_q + 1'b1;
    bclk_d    = terminal ? ~bclk_q : bclk_q;
  end

  // Divider and BCLK state.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o      = bclk_q;
  assign fall_tick_o = terminal &  bclk_q;
  assign rise_tick_o = terminal & ~bclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: accepts stereo pairs over a valid/ready handshake into a
// one-deep pending register, then serialises them MSB first to the codec.
// All serial outputs change on BCLK falling edges; the codec samples on rise.
// Build option LEFT_JUSTIFIED_EN selects left-justified framing (MSB in slot
// bit 0) instead of standard I2S (MSB one BCLK after the lrclk change).
module i2s_transmitter import audio_pkg::*; #(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,  // must be <= SLOT_W-1
  parameter int unsigned SLOT_W   = SLOT_W_DEF,
  parameter int unsigned BCLK_DIV = BCLK_DIV_DEF   // even, >= 4
) (
  input  logic            clk,
  input  logic            reset,
  i2s_transmitter_if.slave sif,
  output logic            bclk,
  output logic            lrclk,
  output logic            sdata
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_W;
  localparam int unsigned BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT_BITS = BW'(SLOT_W);
  localparam logic [BW-1:0] DATA_BITS = BW'(SAMPLE_W);

  logic                fall_tick;
  logic                unused_rise_tick;

  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic [SAMPLE_W-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic                pend_full_q, pend_full_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;

  logic                accept;
  logic                frame_load;
  slot_e               slot_d;
  logic [BW-1:0]       slot_bit;
  logic [SAMPLE_W-1:0] ch_word;
  logic [SAMPLE_W-1:0] word_sh;
  logic                serial_bit;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk         (clk),
    .reset       (reset),
    .bclk_o      (bclk),
    .fall_tick_o (fall_tick),
    .rise_tick_o (unused_rise_tick)
  );

  assign sif.sample_ready = !pend_full_q && !reset;

  // Handshake, frame position and the pending/active sample registers.
  // A load only consumes a pair that was already pending before this cycle,
  // so an accept coinciding with the load waits for the next frame.
  always_comb begin
    accept     = sif.sample_valid && sif.sample_ready;
    frame_load = fall_tick && (bit_cnt_q == LAST_BIT);

    bit_cnt_d = bit_cnt_q;
    if (fall_tick) begin
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
    end

    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    pend_full_d = pend_full_q;

    if (frame_load && pend_full_q) begin
      act_l_d     = pend_l_q;
      act_r_d     = pend_r_q;
      pend_full_d = 1'b0;
    end

    if (accept) begin
      pend_l_d    = sif.left_in;
      pend_r_d    = sif.right_in;
      pend_full_d = 1'b1;
    end
  end

  // Next serial bit, derived from the post-tick position and post-load samples.
  always_comb begin
    slot_d     = (bit_cnt_d >= SLOT_BITS) ? SLOT_RIGHT : SLOT_LEFT;
    slot_bit   = (slot_d == SLOT_RIGHT) ? bit_cnt_d - SLOT_BITS : bit_cnt_d;
    ch_word    = (slot_d == SLOT_RIGHT) ? act_r_d : act_l_d;
    serial_bit = 1'b0;
    word_sh    = '0;
`ifdef LEFT_JUSTIFIED_EN
    word_sh = ch_word << slot_bit;
    if (slot_bit < DATA_BITS) begin
      serial_bit = word_sh[SAMPLE_W-1];
    end
`else
    // Slot bit 0 is the previous slot's trailing pad; data starts at bit 1.
    word_sh = ch_word << (slot_bit - 1'b1);
    if ((slot_bit != '0) && (slot_bit <= DATA_BITS)) begin
      serial_bit = word_sh[SAMPLE_W-1];
    end
`endif
    lrclk_d = fall_tick ? (slot_d == SLOT_RIGHT) : lrclk_q;
    sdata_d = fall_tick ? serial_bit : sdata_q;
  end

  // Frame, sample and serial output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q   <= LAST_BIT;
      act_l_q     <= '0;
      act_r_q     <= '0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      pend_full_q <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      pend_full_q <= pend_full_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
    end
  end

  assign lrclk = lrclk_q;
  assign sdata = sdata_q;

endmodule
